// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - 1 Hz minute/hour timekeeper with button-driven set mode (optional CLOCK_H12_EN adds 12-hour outputs)
module clock_time_ctrl #(
    parameter int INIT_HOUR = 12,
    parameter int INIT_MIN  = 0,
    parameter int TIMEOUT   = 30
) (
    input  logic       clk_1Hz,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       sec_run,
    output logic       sec_clr,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [1:0] mode,
    output logic       blink,
    output logic       day_tick
`ifdef CLOCK_H12_EN
    ,
    output logic [3:0] hour12,
    output logic       pm
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_t;

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    mode_t         state;
    mode_t         state_nx;
    logic [5:0]    min_nx;
    logic [4:0]    hour_nx;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_nx;
    logic          blink_nx;
    logic          sec_clr_nx;
    logic          day_tick_nx;
    logic          mode_hist;
    logic          inc_hist;
    logic          mode_press;
    logic          inc_press;

    // A press is a rising level against last cycle's sample; mode wins over inc.
    assign mode_press = btn_mode & ~mode_hist;
    assign inc_press  = btn_inc & ~inc_hist & ~mode_press;

    assign sec_run = (state == RUN);
    assign mode    = state;

    // State and datapath registers; reset restores the power-on time and RUN.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            hour      <= 5'(INIT_HOUR);
            min       <= 6'(INIT_MIN);
            to_cnt    <= '0;
            blink     <= 1'b0;
            sec_clr   <= 1'b0;
            day_tick  <= 1'b0;
            mode_hist <= 1'b0;
            inc_hist  <= 1'b0;
        end else begin
            state     <= state_nx;
            hour      <= hour_nx;
            min       <= min_nx;
            to_cnt    <= to_cnt_nx;
            blink     <= blink_nx;
            sec_clr   <= sec_clr_nx;
            day_tick  <= day_tick_nx;
            mode_hist <= btn_mode;
            inc_hist  <= btn_inc;
        end
    end

    // Next-state: timekeeping in RUN, field edits and inactivity timeout in SET states.
    always_comb begin
        state_nx    = state;
        hour_nx     = hour;
        min_nx      = min;
        to_cnt_nx   = to_cnt;
        blink_nx    = 1'b0;
        sec_clr_nx  = 1'b0;
        day_tick_nx = 1'b0;
        case (state)
            RUN: begin
                to_cnt_nx = '0;
                if (sec_tick) begin
                    if (min == 6'd59) begin
                        min_nx = 6'd0;
                        if (hour == 5'd23) begin
                            hour_nx     = 5'd0;
                            day_tick_nx = 1'b1;
                        end else begin
                            hour_nx = hour + 5'd1;
                        end
                    end else begin
                        min_nx = min + 6'd1;
                    end
                end
                if (mode_press) begin
                    state_nx = SET_HR;
                    blink_nx = 1'b1;
                end
            end
            default: begin
                blink_nx  = ~blink;
                to_cnt_nx = to_cnt + 1'b1;
                if (mode_press) begin
                    to_cnt_nx = '0;
                    blink_nx  = 1'b1;
                    case (state)
                        SET_HR:  state_nx = SET_MIN;
                        SET_MIN: state_nx = SET_SEC;
                        default: begin
                            state_nx = RUN;
                            blink_nx = 1'b0;
                        end
                    endcase
                end else if (inc_press) begin
                    to_cnt_nx = '0;
                    case (state)
                        SET_HR:  hour_nx = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                        SET_MIN: min_nx  = (min == 6'd59) ? 6'd0 : min + 6'd1;
                        default: sec_clr_nx = 1'b1;
                    endcase
                end else if (to_cnt == TO_LAST) begin
                    state_nx  = RUN;
                    blink_nx  = 1'b0;
                    to_cnt_nx = '0;
                end
            end
        endcase
    end

`ifdef CLOCK_H12_EN
    // 12-hour view of the 24-hour register: 0 -> 12 AM, 12 -> 12 PM.
    always_comb begin
        pm = (hour >= 5'd12);
        if (hour == 5'd0) begin
            hour12 = 4'd12;
        end else if (hour <= 5'd12) begin
            hour12 = hour[3:0];
        end else begin
            hour12 = 4'(hour - 5'd12);
        end
    end
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - randomized self-checking bench for clock_time_ctrl against a time-of-day model
module tb_clock_time_ctrl;

    localparam int TIMEOUT = 30;

    logic       clk_1Hz = 1'b0;
    logic       rst;
    logic       sec_tick;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_run;
    logic       sec_clr;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
    logic       blink;
    logic       day_tick;
`ifdef CLOCK_H12_EN
    logic [3:0] hour12;
    logic       pm;
`endif

    clock_time_ctrl #(.INIT_HOUR(12), .INIT_MIN(0), .TIMEOUT(TIMEOUT)) dut (
        .clk_1Hz  (clk_1Hz),
        .rst      (rst),
        .sec_tick (sec_tick),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_run  (sec_run),
        .sec_clr  (sec_clr),
        .min      (min),
        .hour     (hour),
        .mode     (mode),
        .blink    (blink),
        .day_tick (day_tick)
`ifdef CLOCK_H12_EN
        ,
        .hour12   (hour12),
        .pm       (pm)
`endif
    );

    always #5 clk_1Hz = ~clk_1Hz;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: time of day as minutes since midnight, timing by absolute cycle numbers.
    int m_tod;
    int m_mode;
    int m_cycle;
    int m_entry;
    int m_last;
    bit m_pm;
    bit m_pi;
    bit m_clr;
    bit m_day;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tod  = 12 * 60;
        m_mode = 0;
        m_pm   = 1'b0;
        m_pi   = 1'b0;
        m_clr  = 1'b0;
        m_day  = 1'b0;
    endtask

    task automatic model_edge(input bit bm, input bit bi, input bit st);
        bit mp;
        bit ip;
        m_cycle++;
        mp    = bm && !m_pm;
        ip    = bi && !m_pi && !mp;
        m_pm  = bm;
        m_pi  = bi;
        m_clr = 1'b0;
        m_day = 1'b0;
        if (m_mode == 0) begin
            if (st) begin
                m_tod = (m_tod + 1) % 1440;
                m_day = (m_tod == 0);
            end
            if (mp) begin
                m_mode  = 1;
                m_entry = m_cycle;
                m_last  = m_cycle;
            end
        end else if (mp) begin
            m_mode  = (m_mode + 1) % 4;
            m_entry = m_cycle;
            m_last  = m_cycle;
        end else if (ip) begin
            m_last = m_cycle;
            case (m_mode)
                1:       m_tod = ((m_tod / 60 + 1) % 24) * 60 + m_tod % 60;
                2:       m_tod = (m_tod / 60) * 60 + (m_tod % 60 + 1) % 60;
                default: m_clr = 1'b1;
            endcase
        end else if (m_cycle - m_last == TIMEOUT) begin
            m_mode = 0;
        end
    endtask

    task automatic compare_all();
        int h;
        h = m_tod / 60;
        check("hour", 32'(hour), 32'(h));
        check("min", 32'(min), 32'(m_tod % 60));
        check("mode", 32'(mode), 32'(m_mode));
        check("sec_run", 32'(sec_run), 32'(m_mode == 0));
        check("sec_clr", 32'(sec_clr), 32'(m_clr));
        check("day_tick", 32'(day_tick), 32'(m_day));
        check("blink", 32'(blink), 32'((m_mode != 0) && ((m_cycle - m_entry) % 2 == 0)));
`ifdef CLOCK_H12_EN
        check("hour12", 32'(hour12), 32'((h % 12 == 0) ? 12 : h % 12));
        check("pm", 32'(pm), 32'(h >= 12));
`endif
    endtask

    // Inputs are driven 1 time unit after the edge and sampled 1 unit after the next.
    task automatic step(input bit bm, input bit bi, input bit st);
        btn_mode = bm;
        btn_inc  = bi;
        sec_tick = st;
        @(posedge clk_1Hz);
        model_edge(bm, bi, st);
        #1;
        compare_all();
    endtask

    task automatic press(input bit bm, input bit bi);
        step(bm, bi, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_mode", 32'(mode), 32'(0));
        check("rst_min", 32'(min), 32'(0));
        check("rst_hour", 32'(hour), 32'(12));
        compare_all();
        @(posedge clk_1Hz);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        bit bm;
        bit bi;
        int quiet;
        rst      = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        sec_tick = 1'b0;
        m_cycle  = 0;
        m_entry  = 0;
        m_last   = 0;
        model_reset();
        repeat (2) @(posedge clk_1Hz);
        #1;
        check("reset_hour", 32'(hour), 32'(12));
        check("reset_min", 32'(min), 32'(0));
        check("reset_mode", 32'(mode), 32'(0));
        check("reset_sec_run", 32'(sec_run), 32'(1));
        check("reset_sec_clr", 32'(sec_clr), 32'(0));
        check("reset_blink", 32'(blink), 32'(0));
        rst = 1'b0;

        // Set 23:59 through the set sequence, then roll the day over.
        press(1'b1, 1'b0);
        repeat (11) press(1'b0, 1'b1);
        check("set_hr_23", 32'(hour), 32'(23));
        press(1'b1, 1'b0);
        repeat (59) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("back_run", 32'(mode), 32'(0));
        check("at_2359", 32'({hour, min}), 32'({5'd23, 6'd59}));
        step(1'b0, 1'b0, 1'b1);
        check("rollover", 32'({hour, min, day_tick}), 32'({5'd0, 6'd0, 1'b1}));
        step(1'b0, 1'b0, 1'b0);
        check("day_tick_clear", 32'(day_tick), 32'(0));

        // Hour edits wrap, a held inc counts once.
        press(1'b1, 1'b0);
        repeat (13) press(1'b0, 1'b1);
        check("hour_13", 32'(hour), 32'(13));
        repeat (5) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("held_inc", 32'(hour), 32'(14));

        // Minute edits wrap without carry; sec_tick is ignored.
        press(1'b1, 1'b0);
        repeat (58) press(1'b0, 1'b1);
        repeat (3) begin
            step(1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b1);
        end
        check("min_wrap", 32'({hour, min, sec_run}), 32'({5'd14, 6'd1, 1'b0}));

        // Seconds clear pulse, then inactivity timeout.
        press(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("sec_clr_pulse", 32'(sec_clr), 32'(1));
        for (int i = 1; i < TIMEOUT; i++) step(1'b0, 1'b0, 1'b0);
        check("pre_timeout", 32'(mode), 32'(3));
        step(1'b0, 1'b0, 1'b0);
        check("timeout", 32'({mode, sec_run}), 32'({2'd0, 1'b1}));

        // Mode beats inc on the same edge, reset mid-set discards edits.
        press(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("mode_wins", 32'({mode, hour}), 32'({2'd2, 5'd14}));
        step(1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1);
        async_reset();

        // Random traffic, with quiet stretches to let timeouts fire.
        bm    = 1'b0;
        bi    = 1'b0;
        quiet = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                async_reset();
            end else begin
                if (quiet > 0) begin
                    quiet--;
                    bm = 1'b0;
                    bi = 1'b0;
                end else begin
                    if ($urandom_range(0, 59) == 0) quiet = $urandom_range(25, 40);
                    if ($urandom_range(0, 5) == 0) bm = ~bm;
                    if ($urandom_range(0, 2) == 0) bi = ~bi;
                end
                step(bm, bi, $urandom_range(0, 2) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Timekeeping and time-set controller for the digital clock, running on the 1 Hz domain. It consumes the wrap pulse from the seconds counter and owns the minute and hour registers. It also gates the seconds counter through run/clear outputs and sequences a button-driven set mode (hour, minute, seconds-zero). Outputs feed the display/BCD stage.

Parameters:
INIT_HOUR, 12, hour value loaded on reset (0..23)
INIT_MIN, 0, minute value loaded on reset (0..59)
TIMEOUT, 30, clk_1Hz cycles without a button press in any SET state before auto-return to RUN (>=2)

Ports:
clk_1Hz  input  1  1 Hz system clock, rising-edge
rst  input  1  asynchronous, active-high reset
sec_tick  input  1  one-cycle pulse from seconds counter on 59->0 wrap
btn_mode  input  1  mode button level, already synchronized/debounced
btn_inc  input  1  increment button level, already synchronized/debounced
sec_run  output  1  enable to seconds counter; 1 only in RUN
sec_clr  output  1  one-cycle synchronous clear request to seconds counter
min  output  6  minutes 0..59
hour  output  5  hours 0..23
mode  output  2  0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC
blink  output  1  toggles every cycle in SET states (display flash of field being set); 0 in RUN
day_tick  output  1  one-cycle pulse on 23:59 -> 00:00 rollover

Behaviour:
- Reset (async, rst=1): mode=RUN, hour=INIT_HOUR, min=INIT_MIN, sec_run=1, sec_clr=0, blink=0, day_tick=0, timeout counter=0, button history regs=0.
- Press detection: registered prior level per button; press = level 1 at a posedge while history 0. Press acts at that same edge (outputs update after it). Held button = single press.
- FSM on mode press: RUN->SET_HR->SET_MIN->SET_SEC->RUN.
- Simultaneous mode and inc press: mode wins; inc ignored that cycle.
- RUN: sec_tick=1 -> min+1; min 59 -> 0 with hour+1; hour 23 with min 59 -> hour 0, min 0, day_tick=1 for that cycle. inc presses ignored.
- SET_HR: inc -> hour+1 mod 24. SET_MIN: inc -> min+1 mod 60, no carry into hour. SET_SEC: inc -> sec_clr=1 for exactly one cycle.
- SET states: sec_run=0; sec_tick ignored (no minute update); blink toggles each cycle starting at 1 on entry.
- Timeout: counter clears on any press and on entry to a SET state; increments each cycle in SET states. Reaching TIMEOUT-1 with no press -> RUN next edge; edits so far retained.
- Leaving SET_SEC to RUN via mode press: no sec_clr unless inc was pressed.
- Reset mid-set: immediate return to reset values; edits discarded.
- All arithmetic compare-before-increment; min/hour never hold out-of-range values.

Optional Feature:
Macro CLOCK_H12_EN. Defined: adds outputs hour12 (4 bits, 1..12) and pm (1 bit), combinational from hour: 0->12 AM, 1..11 AM, 12->12 PM, 13..23 -> hour-12 PM. Internal hour stays 0..23. Not defined: ports absent; behaviour otherwise identical.

Test Plan:
- Reset with defaults -> hour=12, min=0, mode=0, sec_run=1, sec_clr=0, blink=0.
- From 23:59 in RUN, pulse sec_tick one cycle -> hour=0, min=0, day_tick=1 for one cycle, then 0.
- Mode press x1, inc press x13 (separate presses) -> hour 12->1 (wraps through 23->0); held inc for 5 cycles -> only +1.
- Mode to SET_MIN with min=58, inc x3 -> min=1, hour unchanged; sec_tick pulses meanwhile -> no change, sec_run=0.
- Mode to SET_SEC, inc -> sec_clr=1 exactly one cycle; no further press for 30 cycles -> mode=0, sec_run=1.
- Mode and inc pressed same edge in SET_HR -> mode=2, hour unchanged; assert rst mid-SET_MIN -> mode=0, min=INIT_MIN immediately.
